// File: rtl/req_priority_dispatcher.sv
// Sticky 16-line request capture with highest-index-first dispatch over a
// registered valid/ready offer of a 4-bit line index.
module req_priority_dispatcher #(
    parameter int unsigned N_REQ = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic             en_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [N_REQ-1:0] pend_o,
    output logic             empty_o
);

    typedef enum logic {
        S_IDLE,
        S_OFFER
    } state_t;

    state_t           r_state;
    logic [N_REQ-1:0] r_pend;
    logic             r_valid;
    logic [IDX_W-1:0] r_idx;

    logic             w_accept;
    logic [N_REQ-1:0] w_clr_mask;
    logic [N_REQ-1:0] w_pend_masked;
    logic [IDX_W-1:0] w_winner;
    logic             w_any;

    always_comb begin
        w_accept               = r_valid & ready_i;
        w_clr_mask             = '0;
        w_clr_mask[r_idx]      = w_accept;
        w_pend_masked          = r_pend & ~w_clr_mask;
        w_any                  = |w_pend_masked;
    end

    // Ascending scan so the last hit, i.e. the highest set index, wins.
    always_comb begin
        w_winner = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_pend_masked[i]) begin
                w_winner = i[IDX_W-1:0];
            end
        end
    end

    // Set wins over clear: a request on the just-accepted line stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_pend <= w_pend_masked | req_i;
            case (r_state)
                S_IDLE: begin
                    if (en_i && w_any) begin
                        r_state <= S_OFFER;
                        r_valid <= 1'b1;
                        r_idx   <= w_winner;
                    end
                end
                S_OFFER: begin
                    if (w_accept) begin
                        if (en_i && w_any) begin
                            r_idx <= w_winner;
                        end else begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign valid_o = r_valid;
    assign idx_o   = r_idx;
    assign pend_o  = r_pend;
    assign empty_o = (r_pend == '0) && !r_valid;

endmodule

// File: tb/tb_req_priority_dispatcher.sv
// Directed bench for req_priority_dispatcher: a vector table for the
// single-cycle-checkable flows plus hand-written reset and re-request sequences.
module tb_req_priority_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req_i;
    logic        en_i;
    logic        ready_i;
    logic        valid_o;
    logic [3:0]  idx_o;
    logic [15:0] pend_o;
    logic        empty_o;

    int n_cmp = 0;
    int n_bad = 0;

    req_priority_dispatcher #(.N_REQ(16), .IDX_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_i),
        .en_i    (en_i),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .idx_o   (idx_o),
        .pend_o  (pend_o),
        .empty_o (empty_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] req;
        logic        en;
        logic        rdy;
        logic        ev;
        logic [3:0]  ei;
        logic [15:0] ep;
        logic        ee;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [15:0] req, input logic en, input logic rdy,
                       input logic ev, input logic [3:0] ei, input logic [15:0] ep,
                       input logic ee);
        vec_t v;
        v.req = req; v.en = en; v.rdy = rdy;
        v.ev = ev; v.ei = ei; v.ep = ep; v.ee = ee;
        tbl.push_back(v);
    endtask

    task automatic chk1(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input logic ev, input logic [3:0] ei,
                             input logic [15:0] ep, input logic ee);
        chk1({name, ".valid"}, 16'(valid_o), 16'(ev));
        chk1({name, ".idx"},   16'(idx_o),   16'(ei));
        chk1({name, ".pend"},  pend_o,       ep);
        chk1({name, ".empty"}, 16'(empty_o), 16'(ee));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] req, input logic en, input logic rdy);
        req_i   = req;
        en_i    = en;
        ready_i = rdy;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(16'h0000, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #2 check_all("reset", 1'b0, 4'd0, 16'h0000, 1'b1);
        #9 rst_n = 1'b1;

        drive(16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all($sformatf("idle%0d", i), 1'b0, 4'd0, 16'h0000, 1'b1);
        end

        // 8001 burst: offer 15 one cycle after capture, then 0, then drain
        add(16'h8001, 1, 1, 0, 4'd0,  16'h8001, 0);
        add(16'h0000, 1, 1, 1, 4'd15, 16'h8001, 0);
        add(16'h0000, 1, 1, 1, 4'd0,  16'h0001, 0);
        add(16'h0000, 1, 1, 0, 4'd0,  16'h0000, 1);
        add(16'h0000, 1, 1, 0, 4'd0,  16'h0000, 1);
        // idx 3 held under backpressure while 10 arrives and en drops
        add(16'h0008, 1, 0, 0, 4'd0,  16'h0008, 0);
        add(16'h0000, 1, 0, 1, 4'd3,  16'h0008, 0);
        add(16'h0400, 1, 0, 1, 4'd3,  16'h0408, 0);
        add(16'h0000, 1, 0, 1, 4'd3,  16'h0408, 0);
        add(16'h0000, 0, 0, 1, 4'd3,  16'h0408, 0);
        add(16'h0000, 1, 1, 1, 4'd10, 16'h0400, 0);
        add(16'h0000, 1, 1, 0, 4'd10, 16'h0000, 1);
        // en=0 accumulation, then 8, 1, 0
        add(16'h0003, 0, 1, 0, 4'd10, 16'h0003, 0);
        add(16'h0100, 0, 1, 0, 4'd10, 16'h0103, 0);
        add(16'h0000, 0, 1, 0, 4'd10, 16'h0103, 0);
        add(16'h0000, 1, 1, 1, 4'd8,  16'h0103, 0);
        add(16'h0000, 1, 1, 1, 4'd1,  16'h0003, 0);
        add(16'h0000, 1, 1, 1, 4'd0,  16'h0001, 0);
        add(16'h0000, 1, 1, 0, 4'd0,  16'h0000, 1);
        // re-request of accepted 5 while 2 is also pending
        add(16'h0024, 1, 0, 0, 4'd0,  16'h0024, 0);
        add(16'h0000, 1, 0, 1, 4'd5,  16'h0024, 0);
        add(16'h0020, 1, 1, 1, 4'd2,  16'h0024, 0);
        add(16'h0000, 1, 1, 1, 4'd5,  16'h0020, 0);
        add(16'h0000, 1, 1, 0, 4'd5,  16'h0000, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].req, tbl[i].en, tbl[i].rdy);
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].ep, tbl[i].ee);
        end

        // Accept idx 5 with req_i[5] set and nothing else pending
        drive(16'h0020, 1'b1, 1'b0); tick();
        check_all("rereq_cap", 1'b0, 4'd5, 16'h0020, 1'b0);
        drive(16'h0000, 1'b1, 1'b0); tick();
        check_all("rereq_off", 1'b1, 4'd5, 16'h0020, 1'b0);
        drive(16'h0020, 1'b1, 1'b1); tick();
        check_all("rereq_acc", 1'b0, 4'd5, 16'h0020, 1'b0);
        drive(16'h0000, 1'b1, 1'b0); tick();
        check_all("rereq_again", 1'b1, 4'd5, 16'h0020, 1'b0);
        drive(16'h0000, 1'b1, 1'b1); tick();
        check_all("rereq_done", 1'b0, 4'd5, 16'h0000, 1'b1);

        // Async reset while offering with all lines pending
        drive(16'hFFFF, 1'b1, 1'b0); tick();
        check_all("full_cap", 1'b0, 4'd5, 16'hFFFF, 1'b0);
        drive(16'h0000, 1'b1, 1'b0); tick();
        check_all("full_off", 1'b1, 4'd15, 16'hFFFF, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_all("async_rst", 1'b0, 4'd0, 16'h0000, 1'b1);
        #2 rst_n = 1'b1;
        tick();
        check_all("post_rst", 1'b0, 4'd0, 16'h0000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
